iter_divider: RTL and testbench

Multi-cycle radix-2 restoring divider serving the EX stage's div/divu requests over a start/ready handshake. It computes a 32-bit quotient and remainder, signed or unsigned, one quotient bit per cycle. It returns them as a 64-bit word {remainder, quotient}, which EX writes to HI/LO. EX holds `start_i` high and stalls the pipeline while `ready_o` is low; it drops `start_i` in the cycle `ready_o` is seen high.

---
 rtl/iter_divider.sv | 144 ++++++++++++++
 tb/tb_iter_divider.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// iter_divider
// Multi-cycle radix-2 restoring divider for the EX stage div/divu requests.
// Produces one quotient bit per cycle and returns {remainder, quotient}.
//
// Ports:
//   clk           rising-edge clock
//   resetn        asynchronous active-low reset
//   signed_div_i  1 = signed divide, 0 = unsigned; sampled with the operands
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by EX for the whole operation
//   annul_i       cancel the operation in flight
//   result_o      registered {remainder[63:32], quotient[31:0]}
//   ready_o       one-cycle pulse, result_o valid
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start_i; operands captured on the accepting edge
// ON      | iterating (cnt 0..31), then one finalize cycle (cnt == 32)
// DONE    | result_o committed, ready_o high for this cycle only
module iter_divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] rem_sh;
    logic [32:0] trial;

    assign abs_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // The bit shifted out of rem takes part in the trial subtraction so that
    // unsigned divisors above 2^31 still yield the exact quotient.
    assign rem_sh = {rem_q[30:0], quo_q[31]};
    assign trial  = {rem_q[31], rem_sh} - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    state_d = ST_ON;
                    if (opdata2_i == 32'd0) begin
                        // Divide by zero: preload the finalize cycle so the
                        // result {dividend, all-ones} commits one edge later.
                        rem_d     = opdata1_i;
                        quo_d     = 32'hFFFF_FFFF;
                        dvs_d     = 32'd0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        cnt_d     = 6'd32;
                    end else begin
                        rem_d     = 32'd0;
                        quo_d     = abs_a;
                        dvs_d     = abs_b;
                        neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d = signed_div_i & opdata1_i[31];
                        cnt_d     = 6'd0;
                    end
                end
            end

            ST_ON: begin
                if (annul_i || !start_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q[5]) begin
                    result_d[63:32] = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
                    result_d[31:0]  = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
                    state_d         = ST_DONE;
                end else begin
                    rem_d = trial[32] ? rem_sh : trial[31:0];
                    quo_d = {quo_q[30:0], ~trial[32]};
                    cnt_d = cnt_q + 6'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;

    logic        clk;
    logic        resetn;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    iter_divider dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    // Holds start until ready_o is seen (bounded), then drops it in that cycle.
    // lat = edges after the sampling edge E0 at which ready_o is first seen.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res);
        logic seen;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat  = -1;
        res  = '0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                if (ready_o) begin
                    seen = 1'b1;
                    lat  = i;
                    res  = result_o;
                end
            end
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Abort in ON cycle 'cyc' by annul (start held) or by dropping start.
    task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input int cyc,
                            input logic use_annul, input logic [63:0] prior, input string name);
        int hits;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        repeat (cyc + 1) @(posedge clk);
        @(negedge clk);
        if (use_annul) annul_i = 1'b1;
        else start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) hits++;
        end
        chk({name, "_ready_quiet"}, 64'(hits), 64'd0);
        chk({name, "_result_hold"}, result_o, prior);
    endtask

    vec_t        vecs[$];
    int          lat;
    logic [63:0] res;
    logic [63:0] last_res;
    int          hits;

    initial begin
        resetn       = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 33});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 33});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd2,          64'h00000001_7FFFFFFF, 33});
        vecs.push_back('{1'b0, 32'h1234_5678,  32'd0,          64'h12345678_FFFFFFFF, 1});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'd0,          64'h80000000_FFFFFFFF, 1});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E, 33});
        vecs.push_back('{1'b0, 32'd0,          32'd5,          64'h00000000_00000000, 33});
        vecs.push_back('{1'b0, 32'd5,          32'h8000_0000,  64'h00000005_00000000, 33});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  64'hFFFFFFFF_00000000, 33});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 33});
        vecs.push_back('{1'b0, 32'd1000000,    32'd1000,       64'h00000000_000003E8, 33});
        vecs.push_back('{1'b1, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_80000001, 33});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  64'h7FFFFFFE_00000001, 33});

        #12;
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[k]) begin
            run_op(vecs[k].sgn, vecs[k].a, vecs[k].b, lat, res);
            chk($sformatf("vec%0d_result", k), res, vecs[k].exp_res);
            chk($sformatf("vec%0d_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ready_drop", k), 64'(ready_o), 64'd0);
            chk($sformatf("vec%0d_result_hold", k), result_o, vecs[k].exp_res);
        end
        last_res = 64'h00000000_00000001;
        chk("last_vec_result", result_o, 64'h7FFFFFFE_00000001);
        last_res = 64'h7FFFFFFE_00000001;

        abort_op(32'd1000, 32'd3, 10, 1'b1, last_res, "annul10");
        run_op(1'b0, 32'd1000, 32'd3, lat, res);
        chk("after_annul_result", res, 64'h00000001_0000014D);
        chk("after_annul_latency", 64'(lat), 64'd33);
        last_res = 64'h00000001_0000014D;

        abort_op(32'd50, 32'd4, 10, 1'b0, last_res, "drop10");
        run_op(1'b1, 32'hFFFF_FFCE, 32'd4, lat, res);
        chk("after_drop_result", res, 64'hFFFFFFFE_FFFFFFF4);
        chk("after_drop_latency", 64'(lat), 64'd33);

        // Operands changed mid-operation must be ignored.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'd0;
        signed_div_i = 1'b1;
        hits = -1;
        for (int i = 3; i < 100; i++) begin
            if (hits < 0) begin
                @(posedge clk);
                #1;
                if (ready_o) hits = i;
            end
        end
        chk("opchange_latency", 64'(hits), 64'd33);
        chk("opchange_result", result_o, 64'h00000002_0000000E);

        // Back-to-back: start kept high, new operands applied after ready.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd20;
        opdata2_i    = 32'd3;
        hits = -1;
        for (int i = 1; i < 100; i++) begin
            if (hits < 0) begin
                @(posedge clk);
                #1;
                if (ready_o) hits = i;
            end
        end
        chk("b2b_gap", 64'(hits), 64'd35);
        chk("b2b_result", result_o, 64'h00000002_00000006);
        @(negedge clk);
        start_i = 1'b0;

        // Asynchronous reset between edges in the middle of ON.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset_result", result_o, 64'd0);
        chk("async_reset_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_op(1'b0, 32'd20, 32'd3, lat, res);
        chk("post_reset_result", res, 64'h00000002_00000006);
        chk("post_reset_latency", 64'(lat), 64'd33);
        last_res = res;

        // Random regression against the reference model, with random aborts.
        for (int n = 0; n < 200; n++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2, 3: b = $urandom_range(1, 1000);
                default: b = $urandom;
            endcase
            if (b != 32'd0 && $urandom_range(0, 5) == 0) begin
                abort_op(a, b, $urandom_range(0, 31), 1'($urandom_range(0, 1)), last_res,
                         $sformatf("rand%0d_abort", n));
            end else begin
                run_op(sgn, a, b, lat, res);
                chk($sformatf("rand%0d_result", n), res, ref_div(sgn, a, b));
                chk($sformatf("rand%0d_latency", n), 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
                last_res = ref_div(sgn, a, b);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
